// File: rtl/plotter_pkg.sv
// Shared types, default parameters and arithmetic helpers for the line sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package plotter_pkg;

    localparam int COORD_W_DEF    = 12;
    localparam int DIV_W_DEF      = 16;
    localparam int PULSE_CYC_DEF  = 4;
    localparam int PEN_SETTLE_DEF = 1000;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PEN_WAIT,
        STEP_HI,
        STEP_LO,
        DONE
    } seq_state_t;

    // Magnitude of a sign-extended value; -2^(W-1) maps to 2^(W-1) exactly
    // because the result is computed at 32 bits before the caller narrows it.
    function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
        logic [31:0] u;
        u = v;
        return v[31] ? (~u + 32'd1) : u;
    endfunction

    function automatic logic [31:0] max_u(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_pulse_timer.sv
// Per-step timer: marks the step pulse high window and the end of the step period.
// Latency: outputs are combinational from a counter loaded on the step-start edge.
// Backpressure: none; reloads whenever load is asserted.
module step_pulse_timer
    import plotter_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [DIV_W-1:0] period_eff,
    output logic             pulse_active,
    output logic             period_done
);

    // Cycles remaining in the current step; reads period_eff-1 in the first cycle.
    logic [DIV_W-1:0] cnt;

    // Down-counter: reload at step start, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period_eff - DIV_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    // The first PULSE_CYC cycles of the step are the high window; widen by one bit
    // so the addition cannot wrap for periods near the top of the DIV_W range.
    assign pulse_active = ({1'b0, cnt} + (DIV_W + 1)'(PULSE_CYC)) >= {1'b0, period_eff};
    assign period_done  = (cnt == '0);

endmodule

// File: rtl/plotter_line_sequencer.sv
// Bresenham line sequencer: turns (dx, dy, pen) segments into X/Y step/dir pulses.
// Latency: accept -> SETUP (1 cycle) -> optional pen settle -> steps every period_eff cycles.
// Backpressure: cmd_ready high only in IDLE; one segment in flight, abort returns to IDLE.
module plotter_line_sequencer
    import plotter_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int PULSE_CYC  = PULSE_CYC_DEF,
    parameter int PEN_SETTLE = PEN_SETTLE_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [COORD_W-1:0] cmd_dx,
    input  logic signed [COORD_W-1:0] cmd_dy,
    input  logic                      cmd_pen,
    input  logic        [DIV_W-1:0]   step_period,
    input  logic                      abort,
    output logic                      dir_out_x,
    output logic                      dir_out_y,
    output logic                      step_clk_x,
    output logic                      step_clk_y,
    output logic                      pen_out,
    output logic                      busy,
    output logic                      seg_done
);

    localparam int SETTLE_W = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE + 1) : 1;

    seq_state_t state_q;
    seq_state_t state_d;

    // Segment latched at accept
    logic signed [COORD_W-1:0] dx_q;
    logic signed [COORD_W-1:0] dy_q;
    logic                      pen_q;
    logic        [DIV_W-1:0]   period_q;

    // Working state
    logic                      dir_x_q;
    logic                      dir_y_q;
    logic                      pen_out_q;
    logic signed [COORD_W:0]   err_q;
    logic        [COORD_W-1:0] steps_left;
    logic                      step_x_q;
    logic                      step_y_q;
    logic        [SETTLE_W-1:0] settle_cnt;

    // Combinational segment geometry (dx_q/dy_q are stable for the whole segment)
    logic        [COORD_W-1:0] ax_c;
    logic        [COORD_W-1:0] ay_c;
    logic        [COORD_W-1:0] n_c;
    logic        [COORD_W-1:0] minor_c;
    logic                      x_major;
    logic signed [COORD_W:0]   err_init;
    logic signed [COORD_W:0]   err_base;
    logic signed [COORD_W:0]   err_sub;
    logic signed [COORD_W:0]   err_next;
    logic                      minor_step;
    logic        [COORD_W-1:0] left_base;
    logic        [DIV_W-1:0]   period_eff_c;
    logic                      pen_change;

    // FSM strobes
    logic start_step;
    logic pulse_active;
    logic period_done;
    logic accept;

    assign ax_c     = COORD_W'(abs_mag(32'(dx_q)));
    assign ay_c     = COORD_W'(abs_mag(32'(dy_q)));
    assign x_major  = (ax_c >= ay_c);
    assign n_c      = COORD_W'(max_u(32'(ax_c), 32'(ay_c)));
    assign minor_c  = x_major ? ay_c : ax_c;
    assign err_init = $signed({1'b0, (n_c >> 1)});

    // The first step can launch straight out of SETUP, before err_q/steps_left
    // have been written, so those cycles use the freshly computed values.
    assign err_base   = (state_q == SETUP) ? err_init : err_q;
    assign left_base  = (state_q == SETUP) ? n_c : steps_left;
    assign err_sub    = err_base - $signed({1'b0, minor_c});
    assign minor_step = err_sub[COORD_W];
    assign err_next   = minor_step ? (err_sub + $signed({1'b0, n_c})) : err_sub;

    assign period_eff_c = DIV_W'(max_u(32'(step_period), 32'(2 * PULSE_CYC)));
    assign pen_change   = (pen_q != pen_out_q);
    assign accept       = (state_q == IDLE) && cmd_valid;

    step_pulse_timer #(
        .DIV_W     (DIV_W),
        .PULSE_CYC (PULSE_CYC)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .load         (start_step),
        .period_eff   (period_q),
        .pulse_active (pulse_active),
        .period_done  (period_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/strobe decode; abort overrides everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        seg_done   = 1'b0;
        start_step = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (pen_change) begin
                    state_d = PEN_WAIT;
                end else if (n_c == '0) begin
                    state_d = DONE;
                end else begin
                    state_d    = STEP_HI;
                    start_step = 1'b1;
                end
            end
            PEN_WAIT: begin
                if (settle_cnt == '0) begin
                    if (left_base == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = STEP_HI;
                        start_step = 1'b1;
                    end
                end
            end
            STEP_HI, STEP_LO: begin
                if (period_done) begin
                    if (steps_left == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = STEP_HI;
                        start_step = 1'b1;
                    end
                end else if ((state_q == STEP_HI) && !pulse_active) begin
                    state_d = STEP_LO;
                end
            end
            DONE: begin
                seg_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            start_step = 1'b0;
            seg_done   = 1'b0;
        end
    end

    // Segment latch, Bresenham accumulator, pen and settle bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dx_q       <= '0;
            dy_q       <= '0;
            pen_q      <= 1'b0;
            period_q   <= '0;
            dir_x_q    <= 1'b0;
            dir_y_q    <= 1'b0;
            pen_out_q  <= 1'b0;
            err_q      <= '0;
            steps_left <= '0;
            step_x_q   <= 1'b0;
            step_y_q   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            // Direction is loaded with the command so it is already valid while
            // SETUP runs, a full cycle ahead of the earliest step pulse.
            if (accept) begin
                dx_q     <= cmd_dx;
                dy_q     <= cmd_dy;
                pen_q    <= cmd_pen;
                period_q <= period_eff_c;
                dir_x_q  <= ~cmd_dx[COORD_W-1];
                dir_y_q  <= ~cmd_dy[COORD_W-1];
            end
            if ((state_q == SETUP) && !abort) begin
                err_q      <= err_init;
                steps_left <= n_c;
                settle_cnt <= SETTLE_W'(PEN_SETTLE - 1);
                if (pen_change) begin
                    pen_out_q <= pen_q;
                end
            end
            if ((state_q == PEN_WAIT) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
            // Decide which axes move on this step; major axis always, minor on error wrap.
            if (start_step) begin
                err_q      <= err_next;
                steps_left <= left_base - COORD_W'(1);
                step_x_q   <= x_major ? 1'b1 : minor_step;
                step_y_q   <= x_major ? minor_step : 1'b1;
            end
        end
    end

    assign step_clk_x = (state_q == STEP_HI) && pulse_active && step_x_q;
    assign step_clk_y = (state_q == STEP_HI) && pulse_active && step_y_q;
    assign dir_out_x  = dir_x_q;
    assign dir_out_y  = dir_y_q;
    assign pen_out    = pen_out_q;
    assign busy       = ~cmd_ready;

endmodule

// File: tb/tb_plotter_line_sequencer.sv
// Scoreboard bench: stimulus pushes expected step/done events, a negedge monitor pops them.
// Latency: n/a.
// Backpressure: stimulus waits for IDLE between segments.
module tb_plotter_line_sequencer;
    import plotter_pkg::*;

    localparam int COORD_W    = 12;
    localparam int DIV_W      = 16;
    localparam int PULSE_CYC  = 4;
    localparam int PEN_SETTLE = 1000;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic signed [COORD_W-1:0] cmd_dx;
    logic signed [COORD_W-1:0] cmd_dy;
    logic                      cmd_pen;
    logic        [DIV_W-1:0]   step_period;
    logic                      abort;
    logic                      dir_out_x;
    logic                      dir_out_y;
    logic                      step_clk_x;
    logic                      step_clk_y;
    logic                      pen_out;
    logic                      busy;
    logic                      seg_done;

    always #5 clk = ~clk;

    plotter_line_sequencer #(
        .COORD_W    (COORD_W),
        .DIV_W      (DIV_W),
        .PULSE_CYC  (PULSE_CYC),
        .PEN_SETTLE (PEN_SETTLE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dx      (cmd_dx),
        .cmd_dy      (cmd_dy),
        .cmd_pen     (cmd_pen),
        .step_period (step_period),
        .abort       (abort),
        .dir_out_x   (dir_out_x),
        .dir_out_y   (dir_out_y),
        .step_clk_x  (step_clk_x),
        .step_clk_y  (step_clk_y),
        .pen_out     (pen_out),
        .busy        (busy),
        .seg_done    (seg_done)
    );

    typedef struct {
        bit sx;
        bit sy;
        bit dx;
        bit dy;
        int gap;     // 0: first step of segment, spacing not checked
    } step_exp_t;

    typedef struct {
        bit pen;
        bit fixed;   // 1: done cycle known absolutely (no steps)
        int cyc;
        int per;     // else: done comes one period after the last step start
    } done_exp_t;

    step_exp_t step_q[$];
    done_exp_t done_q[$];

    int checks     = 0;
    int passes     = 0;
    int cyc        = 0;
    int steps_seen = 0;
    int done_cnt   = 0;
    bit trunc_ok   = 1'b0;
    bit model_pen  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    step_exp_t mon_e;
    done_exp_t mon_d;
    logic prev_x = 1'b0, prev_y = 1'b0, pdir_x = 1'b0, pdir_y = 1'b0;
    int   last_start = 0, wx = 0, wy = 0;

    always @(negedge clk) begin
        if ((step_clk_x && !prev_x) || (step_clk_y && !prev_y)) begin
            steps_seen++;
            if (step_q.size() == 0) begin
                check("unexpected_step", 1, 0);
            end else begin
                mon_e = step_q.pop_front();
                check("step_x", int'(step_clk_x), int'(mon_e.sx));
                check("step_y", int'(step_clk_y), int'(mon_e.sy));
                check("dir_x", int'(dir_out_x), int'(mon_e.dx));
                check("dir_y", int'(dir_out_y), int'(mon_e.dy));
                check("dir_x_before_pulse", int'(pdir_x), int'(mon_e.dx));
                check("dir_y_before_pulse", int'(pdir_y), int'(mon_e.dy));
                if (mon_e.gap != 0) check("step_gap", cyc - last_start, mon_e.gap);
            end
            last_start = cyc;
        end
        if (step_clk_x) wx++;
        else begin
            if (prev_x && !trunc_ok) check("pulse_width_x", wx, PULSE_CYC);
            wx = 0;
        end
        if (step_clk_y) wy++;
        else begin
            if (prev_y && !trunc_ok) check("pulse_width_y", wy, PULSE_CYC);
            wy = 0;
        end
        if (seg_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                check("unexpected_seg_done", 1, 0);
            end else begin
                mon_d = done_q.pop_front();
                check("done_steps_pending", step_q.size(), 0);
                check("done_pen", int'(pen_out), int'(mon_d.pen));
                check("done_cycle", cyc, mon_d.fixed ? mon_d.cyc : last_start + mon_d.per);
            end
        end
        prev_x = step_clk_x;
        prev_y = step_clk_y;
        pdir_x = dir_out_x;
        pdir_y = dir_out_y;
    end

    // Reference model: minor-axis step count after k steps is the closed form
    // ceil((k*minor - n/2)/n); an axis steps on step k when that count advances.
    // Call with the bench sitting just after a negedge in IDLE.
    task automatic send(input int dx, input int dy, input bit pen, input int per,
                        input bit abort_with_cmd, input int push_steps, input bit push_done);
        int ax, ay, n, m, h, p, c_prev, c_k;
        bit xmaj, penchg, adv;
        step_exp_t e;
        done_exp_t d;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        n  = (ax > ay) ? ax : ay;
        m  = (ax > ay) ? ay : ax;
        xmaj = (ax >= ay);
        h  = n / 2;
        p  = (per < 2 * PULSE_CYC) ? 2 * PULSE_CYC : per;
        penchg = (pen != model_pen);
        c_prev = 0;
        for (int k = 1; k <= n; k++) begin
            c_k   = (k * m + n - 1 - h) / n;
            adv   = (c_k != c_prev);
            e.sx  = xmaj ? 1'b1 : adv;
            e.sy  = xmaj ? adv : 1'b1;
            e.dx  = (dx >= 0);
            e.dy  = (dy >= 0);
            e.gap = (k == 1) ? 0 : p;
            if (push_steps < 0 || k <= push_steps) step_q.push_back(e);
            c_prev = c_k;
        end
        check("cmd_ready_idle", int'(cmd_ready), 1);
        if (push_done) begin
            d.pen   = pen;
            d.fixed = (n == 0);
            d.cyc   = cyc + 2 + (penchg ? PEN_SETTLE : 0);
            d.per   = p;
            done_q.push_back(d);
        end
        cmd_valid   = 1'b1;
        cmd_dx      = COORD_W'(dx);
        cmd_dy      = COORD_W'(dy);
        cmd_pen     = pen;
        step_period = DIV_W'(per);
        abort       = abort_with_cmd;
        @(negedge clk);
        #1;
        cmd_valid   = 1'b0;
        abort       = 1'b0;
        step_period = DIV_W'($urandom_range(1, 40));
        check("busy_after_accept", int'(busy), 1);
        model_pen = pen;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        check("idle_within_budget", int'(i < budget), 1);
    endtask

    task automatic wait_steps(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (steps_seen >= target) break;
        end
        check("steps_reached", int'(steps_seen >= target), 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_step_x", int'(step_clk_x), 0);
        check("rst_step_y", int'(step_clk_y), 0);
        check("rst_dir_x", int'(dir_out_x), 0);
        check("rst_dir_y", int'(dir_out_y), 0);
        check("rst_pen", int'(pen_out), 0);
        check("rst_seg_done", int'(seg_done), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got busy=%0d, expected completion", busy);
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dcnt, dx, dy, per;
        bit pen;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_dx = '0; cmd_dy = '0;
        cmd_pen = 1'b0; step_period = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        resetn = 1'b1;
        @(negedge clk);
        #1;

        // Abort in IDLE alone is ignored
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle_ready", int'(cmd_ready), 1);

        send(5, 2, 1'b0, 10, 1'b0, -1, 1'b1);     wait_idle(200);
        send(-3, 7, 1'b0, 10, 1'b0, -1, 1'b1);    wait_idle(200);
        send(0, 0, 1'b1, 10, 1'b0, -1, 1'b1);     wait_idle(PEN_SETTLE + 50);
        send(4, -3, 1'b1, 1, 1'b0, -1, 1'b1);     wait_idle(200);
        send(2, 1, 1'b1, 9, 1'b1, -1, 1'b1);      wait_idle(200);   // abort with cmd: accepted
        send(-2048, 0, 1'b1, 8, 1'b0, -1, 1'b1);  wait_idle(2048 * 8 + 100);

        // Abort during the third step pulse
        base = steps_seen;
        dcnt = done_cnt;
        send(10, 0, 1'b1, 10, 1'b0, 3, 1'b0);
        wait_steps(base + 3, 200);
        abort    = 1'b1;
        trunc_ok = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        check("abort_step_low", int'(step_clk_x), 0);
        check("abort_idle", int'(cmd_ready), 1);
        check("abort_dir_kept", int'(dir_out_x), 1);
        check("abort_pen_kept", int'(pen_out), 1);
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_seg_done", done_cnt - dcnt, 0);
        check("abort_no_more_steps", steps_seen - base, 3);
        trunc_ok = 1'b0;

        // Reset in the middle of a segment
        base = steps_seen;
        send(6, 6, 1'b1, 10, 1'b0, 2, 1'b0);
        wait_steps(base + 2, 200);
        resetn   = 1'b0;
        trunc_ok = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs();
        resetn    = 1'b1;
        model_pen = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        trunc_ok = 1'b0;

        // Randomized segments, issued back-to-back as soon as the sequencer is idle
        for (int s = 0; s < 14; s++) begin
            dx  = int'($urandom_range(0, 30)) - 15;
            dy  = int'($urandom_range(0, 30)) - 15;
            per = int'($urandom_range(1, 14));
            pen = ($urandom_range(0, 4) == 0) ? ~model_pen : model_pen;
            send(dx, dy, pen, per, 1'b0, -1, 1'b1);
            wait_idle(30 * 16 + PEN_SETTLE + 50);
        end

        repeat (5) @(negedge clk);
        #1;
        check("step_queue_drained", step_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
